// File: rtl/ball_draw_ctrl.sv
// Ball drawer sequencer for the billiard display.
// Latches each ball's position once per frame, runs the per-ball show/blink/gone
// lifecycle, and merges the per-ball drawer outputs into one registered pixel stream.

module ball_draw_ctrl #(
    parameter int unsigned NUM_BALLS    = 4,
    parameter int unsigned BLINK_FRAMES = 8,
    parameter int unsigned BLINK_COUNT  = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             startOfFrame,
    input  logic [11*NUM_BALLS-1:0]          posX_in,
    input  logic [11*NUM_BALLS-1:0]          posY_in,
    input  logic [NUM_BALLS-1:0]             pocketed,
    input  logic [NUM_BALLS-1:0]             respawn,
    input  logic [NUM_BALLS-1:0]             drawingRequestBall,
    input  logic [8*NUM_BALLS-1:0]           RGBoutBall,
    output logic [11*NUM_BALLS-1:0]          topLeftPosX,
    output logic [11*NUM_BALLS-1:0]          topLeftPosY,
    output logic [NUM_BALLS-1:0]             ballShow,
    output logic                             drawingRequestBalls,
    output logic [7:0]                       RGBoutBalls,
    output logic [$clog2(NUM_BALLS+1)-1:0]   ballsLeft,
    output logic                             allGone
);

    localparam int unsigned FrameW = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned TogW   = $clog2(2 * BLINK_COUNT + 1);
    localparam int unsigned LeftW  = $clog2(NUM_BALLS + 1);

    // Last frame index of a blink half-period, and the toggle index that ends the sequence.
    localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_FRAMES - 1);
    localparam logic [TogW-1:0]   TogLast   = TogW'(2 * BLINK_COUNT - 1);

    // Background pixel when no drawer claims the pixel.
    localparam logic [7:0] RgbTransparent = 8'hFF;

    typedef enum logic [1:0] {
        StActive,
        StBlink,
        StGone
    } ball_state_e;

    ball_state_e              state_q [NUM_BALLS];
    ball_state_e              state_d [NUM_BALLS];
    logic [FrameW-1:0]        frame_cnt_q [NUM_BALLS];
    logic [FrameW-1:0]        frame_cnt_d [NUM_BALLS];
    logic [TogW-1:0]          tog_cnt_q [NUM_BALLS];
    logic [TogW-1:0]          tog_cnt_d [NUM_BALLS];
    logic [NUM_BALLS-1:0]     show_q, show_d;

    logic [11*NUM_BALLS-1:0]  pos_x_q, pos_y_q;

    logic [LeftW-1:0]         left_q, left_d;
    logic                     all_gone_q, all_gone_d;

    logic                     req_q, req_d;
    logic [7:0]               rgb_q, rgb_d;
    logic                     found;

    // Frame-latched positions: drawers only see a new position at frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x_q <= '0;
            pos_y_q <= '0;
        end else if (startOfFrame) begin
            pos_x_q <= posX_in;
            pos_y_q <= posY_in;
        end
    end

    // Per-ball lifecycle state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_BALLS); i++) begin
                state_q[i]     <= StActive;
                frame_cnt_q[i] <= '0;
                tog_cnt_q[i]   <= '0;
            end
            show_q <= '1;
        end else begin
            for (int i = 0; i < int'(NUM_BALLS); i++) begin
                state_q[i]     <= state_d[i];
                frame_cnt_q[i] <= frame_cnt_d[i];
                tog_cnt_q[i]   <= tog_cnt_d[i];
            end
            show_q <= show_d;
        end
    end

    // Per-ball next state: pocket starts a blink, frames pace the toggles, respawn revives.
    always_comb begin
        show_d = show_q;
        for (int i = 0; i < int'(NUM_BALLS); i++) begin
            state_d[i]     = state_q[i];
            frame_cnt_d[i] = frame_cnt_q[i];
            tog_cnt_d[i]   = tog_cnt_q[i];
            unique case (state_q[i])
                StActive: begin
                    // A frame start in the same cycle is not counted toward the blink.
                    if (pocketed[i]) begin
                        state_d[i]     = StBlink;
                        show_d[i]      = 1'b0;
                        frame_cnt_d[i] = '0;
                        tog_cnt_d[i]   = '0;
                    end
                end
                StBlink: begin
                    if (startOfFrame) begin
                        if (frame_cnt_q[i] == FrameLast) begin
                            frame_cnt_d[i] = '0;
                            tog_cnt_d[i]   = tog_cnt_q[i] + TogW'(1);
                            show_d[i]      = ~show_q[i];
                            if (tog_cnt_q[i] == TogLast) begin
                                state_d[i] = StGone;
                                show_d[i]  = 1'b0;
                            end
                        end else begin
                            frame_cnt_d[i] = frame_cnt_q[i] + FrameW'(1);
                        end
                    end
                end
                StGone: begin
                    if (respawn[i]) begin
                        state_d[i] = StActive;
                        show_d[i]  = 1'b1;
                    end
                end
                default: begin
                    state_d[i] = StActive;
                    show_d[i]  = 1'b1;
                end
            endcase
        end
    end

    // Ball count from next state so it moves in step with ballShow.
    always_comb begin
        left_d = '0;
        for (int i = 0; i < int'(NUM_BALLS); i++) begin
            if (state_d[i] != StGone) begin
                left_d = left_d + LeftW'(1);
            end
        end
        all_gone_d = (left_d == '0);
    end

    // Registered ball count and all-gone level.
    always_ff @(posedge clk) begin
        if (reset) begin
            left_q     <= LeftW'(NUM_BALLS);
            all_gone_q <= 1'b0;
        end else begin
            left_q     <= left_d;
            all_gone_q <= all_gone_d;
        end
    end

    // Fixed-priority merge: the lowest-index requesting drawer is on top.
    always_comb begin
        req_d = |drawingRequestBall;
        rgb_d = RgbTransparent;
        found = 1'b0;
        for (int i = 0; i < int'(NUM_BALLS); i++) begin
            if (drawingRequestBall[i] && !found) begin
                rgb_d = RGBoutBall[8*i +: 8];
                found = 1'b1;
            end
        end
    end

    // Merge output register toward the video mux.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= 1'b0;
            rgb_q <= RgbTransparent;
        end else begin
            req_q <= req_d;
            rgb_q <= rgb_d;
        end
    end

    assign topLeftPosX         = pos_x_q;
    assign topLeftPosY         = pos_y_q;
    assign ballShow            = show_q;
    assign drawingRequestBalls = req_q;
    assign RGBoutBalls         = rgb_q;
    assign ballsLeft           = left_q;
    assign allGone             = all_gone_q;

endmodule

// File: tb/tb_ball_draw_ctrl.sv
// Bench for ball_draw_ctrl: directed scenarios then random traffic, checked against
// a frame-count model of each ball's lifecycle.

module tb_ball_draw_ctrl;

    localparam int unsigned NB = 4;
    localparam int unsigned BF = 2;
    localparam int unsigned BC = 1;
    localparam int unsigned LW = $clog2(NB + 1);
    // Frames from pocketing until the ball disappears.
    localparam int TOTAL = 2 * int'(BC) * int'(BF);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              startOfFrame = 1'b0;
    logic [11*NB-1:0]  posX_in = '0;
    logic [11*NB-1:0]  posY_in = '0;
    logic [NB-1:0]     pocketed = '0;
    logic [NB-1:0]     respawn = '0;
    logic [NB-1:0]     drawingRequestBall = '0;
    logic [8*NB-1:0]   RGBoutBall = '0;
    logic [11*NB-1:0]  topLeftPosX;
    logic [11*NB-1:0]  topLeftPosY;
    logic [NB-1:0]     ballShow;
    logic              drawingRequestBalls;
    logic [7:0]        RGBoutBalls;
    logic [LW-1:0]     ballsLeft;
    logic              allGone;

    ball_draw_ctrl #(
        .NUM_BALLS   (NB),
        .BLINK_FRAMES(BF),
        .BLINK_COUNT (BC)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .startOfFrame       (startOfFrame),
        .posX_in            (posX_in),
        .posY_in            (posY_in),
        .pocketed           (pocketed),
        .respawn            (respawn),
        .drawingRequestBall (drawingRequestBall),
        .RGBoutBall         (RGBoutBall),
        .topLeftPosX        (topLeftPosX),
        .topLeftPosY        (topLeftPosY),
        .ballShow           (ballShow),
        .drawingRequestBalls(drawingRequestBalls),
        .RGBoutBalls        (RGBoutBalls),
        .ballsLeft          (ballsLeft),
        .allGone            (allGone)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: -1 = on table; 0..TOTAL-1 = frames seen since pocketing; >= TOTAL = gone.
    int                frames [NB];
    logic [11*NB-1:0]  exp_x, exp_y;
    logic              exp_req;
    logic [7:0]        exp_rgb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input logic rst, input logic sof, input logic [NB-1:0] pk,
                                input logic [NB-1:0] rs, input logic [NB-1:0] rq,
                                input logic [8*NB-1:0] rgb);
        if (rst) begin
            for (int i = 0; i < int'(NB); i++) frames[i] = -1;
            exp_x   = '0;
            exp_y   = '0;
            exp_req = 1'b0;
            exp_rgb = 8'hFF;
        end else begin
            if (sof) begin
                exp_x = posX_in;
                exp_y = posY_in;
            end
            for (int i = 0; i < int'(NB); i++) begin
                if (frames[i] < 0) begin
                    if (pk[i]) frames[i] = 0;
                end else if (frames[i] < TOTAL) begin
                    if (sof) frames[i] = frames[i] + 1;
                end else if (rs[i]) begin
                    frames[i] = -1;
                end
            end
            exp_req = (rq != '0);
            exp_rgb = 8'hFF;
            begin : pick
                for (int i = 0; i < int'(NB); i++) begin
                    if (rq[i]) begin
                        exp_rgb = rgb[8*i +: 8];
                        disable pick;
                    end
                end
            end
        end
    endtask

    task automatic compare(input string tag);
        logic [NB-1:0] es;
        int            left;
        left = 0;
        for (int i = 0; i < int'(NB); i++) begin
            if (frames[i] < 0)           es[i] = 1'b1;
            else if (frames[i] >= TOTAL) es[i] = 1'b0;
            else                         es[i] = ((frames[i] / int'(BF)) % 2) == 1;
            if (frames[i] < TOTAL) left++;
        end
        check({tag, ".posX"},  64'(topLeftPosX),         64'(exp_x));
        check({tag, ".posY"},  64'(topLeftPosY),         64'(exp_y));
        check({tag, ".show"},  64'(ballShow),            64'(es));
        check({tag, ".req"},   64'(drawingRequestBalls), 64'(exp_req));
        check({tag, ".rgb"},   64'(RGBoutBalls),         64'(exp_rgb));
        check({tag, ".left"},  64'(ballsLeft),           64'(left));
        check({tag, ".allg"},  64'(allGone),             64'(left == 0));
    endtask

    task automatic step(input string tag, input logic rst, input logic sof,
                        input logic [NB-1:0] pk, input logic [NB-1:0] rs,
                        input logic [NB-1:0] rq, input logic [8*NB-1:0] rgb);
        reset              = rst;
        startOfFrame       = sof;
        pocketed           = pk;
        respawn            = rs;
        drawingRequestBall = rq;
        RGBoutBall         = rgb;
        @(posedge clk);
        model_update(rst, sof, pk, rs, rq, rgb);
        #1;
        compare(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic frame(input string tag);
        idle(tag);
        step(tag, 1'b0, 1'b1, '0, '0, '0, '0);
    endtask

    initial begin
        logic [NB-1:0]   pk, rs, rq;
        logic [8*NB-1:0] rgb;

        // Reset state
        step("rst", 1'b1, 1'b0, '0, '0, '0, '0);
        check("rst.show_const", 64'(ballShow), 64'hF);
        check("rst.left_const", 64'(ballsLeft), 64'd4);
        check("rst.rgb_const",  64'(RGBoutBalls), 64'hFF);
        idle("post_rst");

        // Position latch on frame start; mid-frame changes must not leak through
        posX_in[10:0] = 11'd100;
        posY_in[10:0] = 11'd50;
        step("t1_sof", 1'b0, 1'b1, '0, '0, '0, '0);
        check("t1.x0", 64'(topLeftPosX[10:0]), 64'd100);
        check("t1.y0", 64'(topLeftPosY[10:0]), 64'd50);
        posX_in[10:0] = 11'd7;
        posY_in[10:0] = 11'd9;
        idle("t1_mid");
        check("t1.x0_hold", 64'(topLeftPosX[10:0]), 64'd100);

        // Pocket ball 1: off, on after 2 frames, gone after 4
        step("t2_pk", 1'b0, 1'b0, 4'b0010, '0, '0, '0);
        check("t2.show1_off", 64'(ballShow[1]), 64'd0);
        frame("t2_f1");
        frame("t2_f2");
        check("t2.show1_on", 64'(ballShow[1]), 64'd1);
        frame("t2_f3");
        frame("t2_f4");
        check("t2.show1_gone", 64'(ballShow[1]), 64'd0);
        check("t2.left", 64'(ballsLeft), 64'd3);

        // Merge priority: ball 0 wins over ball 2
        rgb = '0;
        rgb[7:0]   = 8'hC0;
        rgb[23:16] = 8'h1C;
        step("t3_req", 1'b0, 1'b0, '0, '0, 4'b0101, rgb);
        check("t3.rgb", 64'(RGBoutBalls), 64'hC0);
        check("t3.req", 64'(drawingRequestBalls), 64'd1);
        idle("t3_none");
        check("t3.rgb_none", 64'(RGBoutBalls), 64'hFF);
        check("t3.req_none", 64'(drawingRequestBalls), 64'd0);

        // Pocket coincident with frame start: that frame does not count
        idle("t4_pre");
        step("t4_pk_sof", 1'b0, 1'b1, 4'b0001, '0, '0, '0);
        frame("t4_f1");
        check("t4.show0_first", 64'(ballShow[0]), 64'd0);
        frame("t4_f2");
        check("t4.show0_second", 64'(ballShow[0]), 64'd1);

        // Everything pocketed and finished, then respawn ball 3
        step("t5_pk_all", 1'b0, 1'b0, 4'b1111, '0, '0, '0);
        for (int k = 0; k < 5; k++) frame("t5_f");
        check("t5.allgone", 64'(allGone), 64'd1);
        check("t5.left0", 64'(ballsLeft), 64'd0);
        step("t5_pk_gone", 1'b0, 1'b0, 4'b0001, 4'b0000, '0, '0);
        step("t5_resp3", 1'b0, 1'b0, 4'b0000, 4'b1000, '0, '0);
        check("t5.show3", 64'(ballShow[3]), 64'd1);
        check("t5.allgone_clr", 64'(allGone), 64'd0);
        check("t5.left1", 64'(ballsLeft), 64'd1);
        step("t5_resp_active", 1'b0, 1'b0, 4'b0000, 4'b1000, '0, '0);

        // Respawn ignored mid-blink; reset mid-blink restores everything
        step("t6_pk3", 1'b0, 1'b0, 4'b1000, '0, '0, '0);
        frame("t6_f1");
        step("t6_resp3", 1'b0, 1'b0, 4'b1000, 4'b1000, '0, '0);
        check("t6.show3_blink", 64'(ballShow[3]), 64'd0);
        step("t6_rst", 1'b1, 1'b1, 4'b1111, '0, 4'b0001, rgb);
        check("t6.show_all", 64'(ballShow), 64'hF);
        check("t6.left", 64'(ballsLeft), 64'd4);
        check("t6.req", 64'(drawingRequestBalls), 64'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < int'(NB); i++) begin
                posX_in[11*i +: 11] = 11'($urandom);
                posY_in[11*i +: 11] = 11'($urandom);
                pk[i]               = ($urandom_range(0, 9) == 0);
                rs[i]               = ($urandom_range(0, 9) == 0);
                rq[i]               = ($urandom_range(0, 2) == 0);
                rgb[8*i +: 8]       = 8'($urandom);
            end
            step("rnd", ($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0),
                 pk, rs, rq, rgb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
